// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared widths and FSM encoding for the round-robin ALU scheduler.
package alu_sched_pkg;

    localparam int OPND_W = 8;   // ALU operand width
    localparam int OPC_W  = 3;   // ALU opcode width
    localparam int RES_W  = 16;  // ALU result width
    localparam int CNT_W  = 4;   // wait counter, holds ALU_WAIT up to 15

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_GRANT = GRANT,
        ST_EXEC  = EXEC,
        ST_RESP  = RESP
    } state_e;

endpackage

// File: rtl/alu_rr_sched_rr_pick.sv
// rr_pick: combinational round-robin first-set finder.
// Searches req_i starting at ptr_i and wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    grant_o,
    output logic               any_o
);

    logic [2*NUM_REQ-1:0] rot;
    logic [ID_W:0]        idx;

    // Rotate the doubled request vector so bit 0 is the pointer position,
    // then take the lowest set bit and map it back to an absolute index.
    always_comb begin
        rot     = {req_i, req_i} >> ptr_i;
        idx     = '0;
        grant_o = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_o && rot[i]) begin
                any_o = 1'b1;
                idx   = {1'b0, ptr_i} + (ID_W+1)'(i);
                if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
                grant_o = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: shares one 8-bit ALU among NUM_REQ requesters in round-robin
// order. One operation in flight at a time: IDLE -> GRANT -> EXEC -> RESP.
// Optional completed-operation counter: define ALU_RR_SCHED_STATS_EN.
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int ALU_WAIT = 1
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_aresetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OPND_W*NUM_REQ-1:0] req_a,
    input  logic [OPND_W*NUM_REQ-1:0] req_b,
    input  logic [OPC_W*NUM_REQ-1:0]  req_opcode,
    output logic [OPND_W-1:0]         alu_a,
    output logic [OPND_W-1:0]         alu_b,
    output logic [OPC_W-1:0]          alu_opcode,
    output logic                      alu_ena,
    input  logic [RES_W-1:0]          alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [RES_W-1:0]          rsp_result,
    output logic                      busy,
    output logic [31:0]               op_count
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, grant_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [OPND_W-1:0]   a_q, b_q;
    logic [OPC_W-1:0]    opc_q;
    logic                rsp_valid_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [RES_W-1:0]    rsp_res_q;

    logic [ID_W-1:0]     pick_id;
    logic                pick_any;

    logic [NUM_REQ-1:0]  grant_oh;
    logic                sel_vld;
    logic [OPND_W-1:0]   sel_a, sel_b;
    logic [OPC_W-1:0]    sel_opc;
    logic [ID_W-1:0]     ptr_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_id),
        .any_o   (pick_any)
    );

    // Select the granted requester's lanes with constant indices only.
    always_comb begin
        grant_oh = '0;
        sel_vld  = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        sel_opc  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == ID_W'(i)) begin
                grant_oh[i] = 1'b1;
                sel_vld     = req_valid[i];
                sel_a       = req_a[i*OPND_W +: OPND_W];
                sel_b       = req_b[i*OPND_W +: OPND_W];
                sel_opc     = req_opcode[i*OPC_W +: OPC_W];
            end
        end
    end

    assign ptr_next = (grant_q == ID_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;

    // FSM state register.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) state_q <= ST_IDLE;
        else                state_q <= state_d;
    end

    // FSM next state plus the handshake/enable strobes that follow the state.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        alu_ena   = 1'b0;
        case (state_q)
            ST_IDLE:  if (pick_any) state_d = ST_GRANT;
            ST_GRANT: begin
                req_ready = grant_oh;
                // A requester that withdrew its valid gets no handshake.
                state_d   = sel_vld ? ST_EXEC : ST_IDLE;
            end
            ST_EXEC: begin
                alu_ena = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: winner capture, operand latch, wait count, response hold, pointer.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            ptr_q       <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            opc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_res_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (pick_any) grant_q <= pick_id;
                ST_GRANT: if (sel_vld) begin
                    a_q   <= sel_a;
                    b_q   <= sel_b;
                    opc_q <= sel_opc;
                    cnt_q <= CNT_W'(ALU_WAIT);
                end
                ST_EXEC: begin
                    if (cnt_q == CNT_W'(1)) begin
                        rsp_res_q   <= alu_result;
                        rsp_id_q    <= grant_q;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    ptr_q       <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_opcode = opc_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_res_q;
    assign busy       = (state_q != ST_IDLE);

`ifdef ALU_RR_SCHED_STATS_EN
    logic [31:0] ops_q;

    // Saturating count of completed response handshakes.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn)                                   ops_q <= '0;
        else if (rsp_valid_q && rsp_ready && ops_q != '1)     ops_q <= ops_q + 32'd1;
    end

    assign op_count = ops_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// tb_alu_rr_sched: directed + randomized checks of alu_rr_sched against a
// transaction-level model (pointer, per-requester pending counts, ALU function).
module tb_alu_rr_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int W   = 2;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid, req_ready;
    logic [8*N-1:0]  req_a, req_b;
    logic [3*N-1:0]  req_opcode;
    logic [7:0]      alu_a, alu_b;
    logic [2:0]      alu_opcode;
    logic            alu_ena;
    logic [15:0]     alu_result;
    logic            rsp_valid, rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [15:0]     rsp_result;
    logic            busy;
    logic [31:0]     op_count;

    always #5 clk = ~clk;

    alu_rr_sched #(.NUM_REQ(N), .ID_W(IDW), .ALU_WAIT(W)) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_opcode    (req_opcode),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_opcode    (alu_opcode),
        .alu_ena       (alu_ena),
        .alu_result    (alu_result),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_result    (rsp_result),
        .busy          (busy),
        .op_count      (op_count)
    );

    // Requester model: pending op count and current operands per requester.
    int         rem [N];
    logic [7:0] ma  [N];
    logic [7:0] mb  [N];
    logic [2:0] mop [N];
    int         ptr_m, ops_m;
    bit         keep_a;
    int         n_cmp, n_err;
    logic [15:0] last_res;

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] op);
        case (op)
            3'd0:    return 16'(a) + 16'(b);
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return {8'h00, a & b};
            3'd4:    return {8'h00, a | b};
            3'd5:    return {8'h00, a ^ b};
            3'd6:    return {a, b};
            default: return {8'h00, ~a};
        endcase
    endfunction

    // Stand-in ALU: garbage whenever it is not enabled.
    assign alu_result = alu_ena ? alu_f(alu_a, alu_b, alu_opcode) : 16'hDEAD;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = (rem[i] > 0);
            req_a[i*8 +: 8]      = ma[i];
            req_b[i*8 +: 8]      = mb[i];
            req_opcode[i*3 +: 3] = mop[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_ref();
        for (int i = 0; i < N; i++) begin
            int j;
            j = (ptr_m + i) % N;
            if (rem[j] > 0) return j;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_cnt();
`ifdef ALU_RR_SCHED_STATS_EN
        return 32'(ops_m);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_alu_a"},     32'(alu_a), 32'd0);
        chk({tag, "_alu_b"},     32'(alu_b), 32'd0);
        chk({tag, "_alu_opc"},   32'(alu_opcode), 32'd0);
        chk({tag, "_alu_ena"},   32'(alu_ena), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id), 32'd0);
        chk({tag, "_rsp_res"},   32'(rsp_result), 32'd0);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_op_count"},  op_count, 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn  = 1'b1;
        ptr_m = 0;
        ops_m = 0;
    endtask

    task automatic wait_grant(output bit ok);
        int k;
        k = 0;
        while (req_ready === '0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        ok = (k < 40);
        if (!ok) chk("grant_timeout", 32'(k), 32'd0);
    endtask

    // Serve one operation: grant order, operand latch, latency, result,
    // optional response back-pressure of 'hold' cycles, then return to idle.
    task automatic serve_one(input int hold, output int got_id);
        int          e, k;
        bit          ok;
        logic [15:0] er;
        logic [7:0]  ea, eb;
        logic [2:0]  eo;
        got_id = -1;
        e = pick_ref();
        wait_grant(ok);
        if (!ok || e < 0) return;
        chk("grant_onehot", 32'(req_ready), 32'(1) << e);
        ea = ma[e]; eb = mb[e]; eo = mop[e];
        er = alu_f(ea, eb, eo);
        @(negedge clk);
        k = 1;
        chk("exec_ena", 32'(alu_ena), 32'd1);
        chk("exec_a",   32'(alu_a), 32'(ea));
        chk("exec_b",   32'(alu_b), 32'(eb));
        chk("exec_opc", 32'(alu_opcode), 32'(eo));
        rem[e]--;
        mb[e]  = 8'($urandom);
        mop[e] = 3'($urandom);
        if (!keep_a) ma[e] = 8'($urandom);
        while (rsp_valid !== 1'b1 && k < W + 6) begin
            chk("exec_no_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            k++;
        end
        chk("latency", 32'(k), 32'(W + 1));
        chk("rsp_id",  32'(rsp_id), 32'(e));
        chk("rsp_res", 32'(rsp_result), 32'(er));
        got_id   = int'(rsp_id);
        last_res = rsp_result;
        if (hold > 0) begin
            rsp_ready = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                chk("bp_valid", 32'(rsp_valid), 32'd1);
                chk("bp_id",    32'(rsp_id), 32'(e));
                chk("bp_res",   32'(rsp_result), 32'(er));
                chk("bp_ready", 32'(req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        ptr_m = (e + 1) % N;
        ops_m++;
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("op_count", op_count, exp_cnt());
    endtask

    initial begin
        int id;
        bit ok;
        int seq [6] = '{0, 1, 2, 3, 0, 1};
        n_cmp = 0; n_err = 0; keep_a = 1'b0; last_res = '0;
        ptr_m = 0; ops_m = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; ma[i] = '0; mb[i] = '0; mop[i] = '0;
        end
        rsp_ready = 1'b1;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rstn = 1'b1;
        @(negedge clk);

        // Single ADD from requester 2.
        ma[2] = 8'h12; mb[2] = 8'h34; mop[2] = 3'b000; rem[2] = 1;
        serve_one(0, id);
        chk("single_id", 32'(id), 32'd2);
        chk("single_res", 32'(last_res), 32'h0046);

        // All requesters valid, distinct a; expect 0,1,2,3,0,1.
        do_reset();
        keep_a = 1'b1;
        for (int i = 0; i < N; i++) begin
            ma[i] = 8'(i + 1); mb[i] = 8'($urandom); mop[i] = 3'($urandom);
        end
        rem[0] = 2; rem[1] = 2; rem[2] = 1; rem[3] = 1;
        for (int s = 0; s < 6; s++) begin
            serve_one(0, id);
            chk("rr_seq", 32'(id), 32'(seq[s]));
        end
        keep_a = 1'b0;

        // Response back-pressure for 10 cycles.
        ma[3] = 8'($urandom); rem[3] = 1;
        serve_one(10, id);
        chk("bp_id_final", 32'(id), 32'd3);

        // Pointer wrap after serving 3: requesters 0 and 3 pending.
        rem[0] = 1; rem[3] = 1;
        serve_one(0, id);
        chk("wrap_first", 32'(id), 32'd0);
        serve_one(0, id);
        chk("wrap_second", 32'(id), 32'd3);

        // Requester withdraws valid during GRANT: no handshake, no response.
        rem[1] = 1;
        wait_grant(ok);
        chk("drop_grant", 32'(req_ready), 32'b0010);
        rem[1] = 0;
        @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_ready", 32'(req_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
        end

        // Randomized request mixes with random back-pressure.
        for (int r = 0; r < 15; r++) begin
            int tot;
            tot = 0;
            for (int i = 0; i < N; i++) begin
                rem[i] = $urandom_range(0, 2);
                tot += rem[i];
            end
            if (tot == 0) rem[r % N] = 1;
            while (pick_ref() >= 0) serve_one($urandom_range(0, 3), id);
        end

        // Reset in the middle of EXEC aborts silently.
        rem[2] = 1;
        wait_grant(ok);
        @(negedge clk);
        rem[2] = 0;
        rstn = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_exec");
        rstn = 1'b1;
        ptr_m = 0; ops_m = 0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        rem[1] = 1;
        serve_one(0, id);
        chk("post_reset_id", 32'(id), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_rr_sched.md
Name: alu_rr_sched

Overview:
Round-robin scheduler that shares one 8-bit ALU instance among NUM_REQ on-chip requesters (DMA engine, PS-side AXI-Lite shim, test pattern generator).
- Accepts one operation per requester through a valid/ready handshake and drives the shared ALU operand/opcode/enable pins.
- Waits a fixed number of cycles for the ALU to settle, captures the 16-bit result and returns it with the requester ID through a valid/ready response channel.
- Sits between the requesters and the ALU, in the same clock domain as the AXI-Lite fabric.

Parameters:
- NUM_REQ, 4, number of requesters; 2..8.
- ID_W, 2, requester ID width; must be at least clog2(NUM_REQ).
- ALU_WAIT, 1, cycles alu_ena is held before the result is sampled; 1..15.

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset; synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  8*NUM_REQ  operand A; requester i occupies bits [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B; same packing as req_a.
- req_opcode  in  3*NUM_REQ  opcode; requester i occupies bits [3i+2:3i].
- alu_a  out  8  to ALU a.
- alu_b  out  8  to ALU b.
- alu_opcode  out  3  to ALU opcode.
- alu_ena  out  1  to ALU ena.
- alu_result  in  16  from ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester served.
- rsp_result  out  16  captured ALU result.
- busy  out  1  high in any state other than IDLE.
- op_count  out  32  completed-operation counter (see Optional Feature).

Behaviour:
- Reset values: req_ready=0, alu_a=0, alu_b=0, alu_opcode=0, alu_ena=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, op_count=0, RR pointer=0, state=IDLE. A reset asserted mid-operation aborts it silently; no response is produced.
- State machine states: IDLE, GRANT, EXEC, RESP.
- IDLE:
  - If any req_valid is high, pick the first valid index searching from ptr upward, wrapping modulo NUM_REQ.
  - Register the winner as grant_id and go to GRANT.
  - Requester selection is registered; requests arriving during other states wait.
- GRANT (1 cycle):
  - req_ready[grant_id]=1; all other bits 0.
  - Latch that requester's operands and opcode into alu_a/alu_b/alu_opcode.
  - Load the wait counter with ALU_WAIT; go to EXEC.
  - If req_valid[grant_id] has dropped in this cycle: no handshake, return to IDLE, ptr unchanged. Requesters should not do this, but the block must tolerate it.
- EXEC:
  - alu_ena=1; decrement the counter each cycle.
  - When the counter reaches 1: capture rsp_result<=alu_result and rsp_id<=grant_id, set rsp_valid=1, drop alu_ena, go to RESP.
  - alu_a/alu_b/alu_opcode hold stable until the next GRANT.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_result until rsp_valid&&rsp_ready.
  - On that handshake: rsp_valid<=0, ptr<=grant_id+1 (wrap to 0 at NUM_REQ), go to IDLE.
  - Back-pressure is unbounded.
- Latency:
  - GRANT cycle to rsp_valid is ALU_WAIT+1 cycles.
  - Minimum issue interval is ALU_WAIT+3 cycles when rsp_ready is held high.
- Fairness: a continuously-valid requester is served at most once every NUM_REQ grants when all requesters are valid.
- Unused high-order ID encodings (index >= NUM_REQ) are never produced.

Optional Feature:
- Macro: ALU_RR_SCHED_STATS_EN.
- Defined: op_count increments by 1 on every rsp_valid&&rsp_ready handshake, saturates at 32'hFFFF_FFFF and clears only on reset.
- Undefined: no counter logic is built; op_count is tied to 0.

Decomposition:
- Package alu_sched_pkg holds:
  - state encoding localparams (IDLE=0, GRANT=1, EXEC=2, RESP=3);
  - OPND_W=8, OPC_W=3, RES_W=16.
- Sub-module rr_pick: combinational round-robin first-set finder.
  - Inputs: req vector, ptr.
  - Outputs: grant index and any-valid flag.
  - Instantiated once.

Test Plan:
- Single request: requester 2 issues ADD (3'b000), a=0x12, b=0x34 with rsp_ready=1.
  -> req_ready[2] pulses once; rsp_valid rises ALU_WAIT+1 cycles after GRANT with rsp_id=2 and rsp_result=0x0046; busy returns to 0.
- All four valid continuously, each with a distinct a (0x01..0x04).
  -> rsp_id sequence 0,1,2,3,0,1 and every rsp_result matches that requester's operands.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid.
  -> rsp_valid, rsp_id and rsp_result stay stable; no req_ready pulses; completes one cycle after rsp_ready=1.
- RR pointer after serving 3: requesters 0 and 3 both valid.
  -> grant goes to 0 (wrap), then 3.
- Reset mid-EXEC: drive s_axi_aresetn=0 on a clock edge.
  -> next cycle all outputs at reset values; no response emitted for the aborted operation.
- With ALU_RR_SCHED_STATS_EN defined: 5 completed operations -> op_count=5. Without the macro: op_count=0 throughout.
